// File: rtl/hdd_pkg.sv
// hdd_pkg: shared types and note-word field positions for the hard-drive music player
package hdd_pkg;
  typedef enum logic {PWM, PDM} output_types_t;
  localparam int PACKET_SIZE = 24;
  localparam int PERIOD_MSB = 23;
  localparam int PERIOD_LSB = 8;
  localparam int AMP_MSB = 7;
endpackage

// File: rtl/hdd_tone_gen.sv
// hdd_tone_gen: one track's step timer, two-phase-on sequencer and amplitude-gated coil drive
module hdd_tone_gen
  import hdd_pkg::*;
#(
  parameter output_types_t OUTPUT_TYPE = PWM,
  parameter int STEPS_PER_DIR = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   tick,
  input  logic                   commit,
  input  logic [PACKET_SIZE-1:0] note,
  input  logic [7:0]             cnt,
  output logic [3:0]             coil
);
  localparam int SW = $clog2(STEPS_PER_DIR + 1);
  logic [PERIOD_MSB-PERIOD_LSB:0] period, tcnt;
  logic [AMP_MSB:0] amp;
  logic [1:0] phase;
  logic [SW-1:0] scnt;
  logic [8:0] acc;
  logic dir, step, wrap, en, live;
  assign period = note[PERIOD_MSB:PERIOD_LSB];
  assign amp = note[AMP_MSB:0];
  assign live = period != '0;
  assign step = tick && live && !commit && tcnt == period - 1'b1;
  assign wrap = scnt == SW'(STEPS_PER_DIR - 1);
  assign en = OUTPUT_TYPE == PDM ? acc[8] : cnt < amp;
  // tick counter restarts on every new note and after each step
  always_ff @(posedge clk or negedge reset)
    if (!reset) tcnt <= '0;
    else if (commit || step) tcnt <= '0;
    else if (tick && live) tcnt <= tcnt + 1'b1;
  // phase walks forward or backward, direction flipping every STEPS_PER_DIR steps
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      phase <= '0;
      dir <= 1'b0;
      scnt <= '0;
    end else if (step) begin
      phase <= dir ? phase - 1'b1 : phase + 1'b1;
      scnt <= wrap ? '0 : scnt + 1'b1;
      dir <= wrap ? ~dir : dir;
    end
  // first-order delta-sigma accumulator; carry out is the PDM enable
  always_ff @(posedge clk or negedge reset)
    if (!reset) acc <= '0;
    else acc <= {1'b0, acc[7:0]} + 9'(amp);
  // registered coils {A,B,C,D}: AB, BC, CD, DA for phase 0..3
  always_ff @(posedge clk or negedge reset)
    if (!reset) coil <= '0;
    else coil <= {phase[0] ~^ phase[1], ~phase[1], phase[0] ^ phase[1], phase[1]} & {4{en && live}};
endmodule

// File: rtl/hdd_tone_top.sv
// hdd_tone_top: SPI note receiver driving NUM_TRACKS amplitude-modulated 4-phase coil outputs
module hdd_tone_top
  import hdd_pkg::*;
#(
  parameter int NUM_TRACKS = 4,
  parameter output_types_t OUTPUT_TYPE = PWM,
  parameter int TICK_DIV = 40,
  parameter int STEPS_PER_DIR = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cs,
  input  logic                  sck,
  input  logic                  sdi,
  output logic [NUM_TRACKS-1:0] A,
  output logic [NUM_TRACKS-1:0] B,
  output logic [NUM_TRACKS-1:0] C,
  output logic [NUM_TRACKS-1:0] D
);
  localparam int LEN = PACKET_SIZE * NUM_TRACKS;
  localparam int PW = $clog2(TICK_DIV + 1);
  logic [LEN-1:0] sh, words;
  logic [1:0] cs_sync;
  logic [PW-1:0] pre;
  logic [7:0] cnt;
  logic commit, tick;
  assign commit = cs_sync[1] & ~cs_sync[0];
  assign tick = pre == PW'(TICK_DIV - 1);
  // SPI shift register clocked by sck; sck is idle while cs is low so the contents are stable at commit
  always_ff @(posedge sck or negedge reset)
    if (!reset) sh <= '0;
    else if (cs) sh <= {sh[LEN-2:0], sdi};
  // cs synchronizer, note latch on cs fall, tick prescaler and shared modulation counter
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      cs_sync <= '0;
      words <= '0;
      pre <= '0;
      cnt <= '0;
    end else begin
      cs_sync <= {cs_sync[0], cs};
      words <= commit ? sh : words;
      pre <= tick ? '0 : pre + 1'b1;
      cnt <= cnt + 1'b1;
    end
  for (genvar k = 0; k < NUM_TRACKS; k++) begin : g_trk
    logic [3:0] coil;
    hdd_tone_gen #(.OUTPUT_TYPE(OUTPUT_TYPE), .STEPS_PER_DIR(STEPS_PER_DIR)) u_gen (
      .clk(clk), .reset(reset), .tick(tick), .commit(commit),
      .note(words[k*PACKET_SIZE +: PACKET_SIZE]), .cnt(cnt), .coil(coil)
    );
    assign {A[k], B[k], C[k], D[k]} = coil;
  end
endmodule

// File: tb/tb_hdd_tone_top.sv
// tb_hdd_tone_top: directed checks of reset, stepping, direction reversal, amplitude and silence
module tb_hdd_tone_top;
  import hdd_pkg::*;
  localparam int NT = 4;
  logic clk = 0, reset = 0, cs = 0, sck = 0, sdi = 0;
  logic [NT-1:0] A, B, C, D, Ap, Bp, Cp, Dp;
  int errors = 0, checks = 0, cyc = 0;
  int act_p[NT], act_d[NT];
  logic [3:0] seq[4] = '{4'b1100, 4'b0110, 4'b0011, 4'b1001};
  logic mon_en = 0;
  logic [3:0] mon_p;
  int n[2] = '{0, 0};
  int tc[2][32];
  logic [3:0] lp[2][32];
  bit amb[2][32];
  logic [3:0] last[2] = '{4'h0, 4'h0};
  bit gap[2] = '{1'b1, 1'b1};

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  hdd_tone_top #(.NUM_TRACKS(NT), .OUTPUT_TYPE(PWM), .TICK_DIV(1), .STEPS_PER_DIR(16)) dut (
    .clk(clk), .reset(reset), .cs(cs), .sck(sck), .sdi(sdi), .A(A), .B(B), .C(C), .D(D));
  hdd_tone_top #(.NUM_TRACKS(NT), .OUTPUT_TYPE(PDM), .TICK_DIV(1), .STEPS_PER_DIR(16)) dut_pdm (
    .clk(clk), .reset(reset), .cs(cs), .sck(sck), .sdi(sdi), .A(Ap), .B(Bp), .C(Cp), .D(Dp));

  function automatic logic [3:0] pw(int k);
    return {A[k], B[k], C[k], D[k]};
  endfunction
  function automatic logic [3:0] pd(int k);
    return {Ap[k], Bp[k], Cp[k], Dp[k]};
  endfunction

  // log each new phase pattern of PWM tracks 0/1; a change right after a gap cycle has uncertain timing
  always @(negedge clk)
    if (mon_en)
      for (int t = 0; t < 2; t++) begin
        mon_p = pw(t);
        if (mon_p != 0 && mon_p != last[t] && n[t] < 32) begin
          tc[t][n[t]] = cyc;
          lp[t][n[t]] = mon_p;
          amb[t][n[t]] = gap[t];
          n[t]++;
        end
        if (mon_p != 0) last[t] = mon_p;
        gap[t] = mon_p == 0;
      end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic shift_bits(input logic [95:0] pkt, input int nb);
    for (int i = 0; i < nb; i++) begin
      sdi = pkt[95-i];
      #2 sck = 1;
      #2 sck = 0;
    end
  endtask

  task automatic send_packet(input logic [95:0] pkt);
    cs = 1;
    #2;
    shift_bits(pkt, 96);
    #2 cs = 0;
  endtask

  task automatic count_active();
    for (int k = 0; k < NT; k++) begin
      act_p[k] = 0;
      act_d[k] = 0;
    end
    repeat (256) begin
      @(negedge clk);
      for (int k = 0; k < NT; k++) begin
        act_p[k] += int'(|pw(k));
        act_d[k] += int'(|pd(k));
      end
    end
  endtask

  task automatic check_counts(input string tag, input int e0, input int e1, input int e2, input int e3);
    int exp_c[NT];
    exp_c = '{e0, e1, e2, e3};
    count_active();
    for (int k = 0; k < NT; k++) begin
      checks++;
      if (act_p[k] !== exp_c[k]) begin
        errors++;
        $display("FAIL %s_pwm trk%0d: active=%0d expected=%0d", tag, k, act_p[k], exp_c[k]);
      end
      checks++;
      if (act_d[k] !== exp_c[k]) begin
        errors++;
        $display("FAIL %s_pdm trk%0d: active=%0d expected=%0d", tag, k, act_d[k], exp_c[k]);
      end
    end
  endtask

  task automatic test_reset();
    int bad = 0;
    reset = 0;
    repeat (5) @(negedge clk);
    checks++;
    if ({A, B, C, D} !== '0) begin
      errors++;
      $display("FAIL reset_pwm: outputs=%h expected=0", {A, B, C, D});
    end
    checks++;
    if ({Ap, Bp, Cp, Dp} !== '0) begin
      errors++;
      $display("FAIL reset_pdm: outputs=%h expected=0", {Ap, Bp, Cp, Dp});
    end
    reset = 1;
    repeat (600) begin
      @(negedge clk);
      if ({A, B, C, D, Ap, Bp, Cp, Dp} !== '0) bad++;
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL idle_after_reset: nonzero cycles=%0d expected=0", bad);
    end
  endtask

  task automatic check_intervals(input int t, input int period);
    int v = 0;
    for (int i = 1; i < n[t]; i++)
      if (!amb[t][i] && !amb[t][i-1]) begin
        v++;
        checks++;
        if (tc[t][i] - tc[t][i-1] !== period) begin
          errors++;
          $display("FAIL step_interval trk%0d #%0d: got=%0d expected=%0d", t, i, tc[t][i] - tc[t][i-1], period);
        end
      end
    checks++;
    if (v < 2) begin
      errors++;
      $display("FAIL interval_samples trk%0d: got=%0d expected>=2", t, v);
    end
  endtask

  task automatic test_load();
    mon_en = 1;
    send_packet(96'h0114ff_0217ff_0114ff_0217ff);
    for (int i = 0; i < 4000 && n[1] < 6; i++) @(negedge clk);
    checks++;
    if (n[1] < 6) begin
      errors++;
      $display("FAIL load_steps: entries=%0d expected>=6", n[1]);
    end
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (lp[1][i] !== seq[i%4]) begin
        errors++;
        $display("FAIL load_phase trk1 #%0d: got=%b expected=%b", i, lp[1][i], seq[i%4]);
      end
    end
    check_intervals(1, 276);
  endtask

  task automatic test_direction();
    logic [3:0] e;
    for (int i = 0; i < 7000 && n[1] < 20; i++) @(negedge clk);
    checks++;
    if (n[1] < 20) begin
      errors++;
      $display("FAIL dir_steps: entries=%0d expected>=20", n[1]);
    end
    for (int i = 0; i < 20; i++) begin
      e = seq[i <= 16 ? i % 4 : (32 - i) % 4];
      checks++;
      if (lp[1][i] !== e) begin
        errors++;
        $display("FAIL dir_phase trk1 #%0d: got=%b expected=%b", i, lp[1][i], e);
      end
    end
    checks++;
    if (n[0] < 5) begin
      errors++;
      $display("FAIL trk0_steps: entries=%0d expected>=5", n[0]);
    end
    for (int i = 0; i < n[0] && i < 12; i++) begin
      checks++;
      if (lp[0][i] !== seq[i%4]) begin
        errors++;
        $display("FAIL trk0_phase #%0d: got=%b expected=%b", i, lp[0][i], seq[i%4]);
      end
    end
    check_intervals(0, 535);
    mon_en = 0;
  endtask

  task automatic test_amplitude();
    int bad = 0;
    logic prev, cur;
    send_packet(96'hffff01_ffffff_ffff80_ffff00);
    repeat (5) @(negedge clk);
    check_counts("amp", 0, 128, 255, 1);
    @(negedge clk);
    prev = |pd(1);
    repeat (16) begin
      @(negedge clk);
      cur = |pd(1);
      if (cur == prev) bad++;
      prev = cur;
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL pdm_alternate: repeats=%0d expected=0", bad);
    end
  endtask

  task automatic test_silence();
    int bad = 0;
    cs = 1;
    #2;
    shift_bits(96'h0000ff_0000ff_0000ff_0000ff, 96);
    @(negedge clk);
    cs = 0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({A, B, C, D} !== '0) begin
      errors++;
      $display("FAIL silence_pwm: outputs=%h expected=0", {A, B, C, D});
    end
    checks++;
    if ({Ap, Bp, Cp, Dp} !== '0) begin
      errors++;
      $display("FAIL silence_pdm: outputs=%h expected=0", {Ap, Bp, Cp, Dp});
    end
    repeat (300) begin
      @(negedge clk);
      if ({A, B, C, D, Ap, Bp, Cp, Dp} !== '0) bad++;
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL silence_hold: nonzero cycles=%0d expected=0", bad);
    end
  endtask

  task automatic test_reset_mid_frame();
    int bad = 0;
    send_packet(96'h000000_ffff80_000000_000000);
    repeat (5) @(negedge clk);
    cs = 1;
    #2;
    shift_bits({96{1'b1}}, 40);
    #3 reset = 0;
    #1;
    checks++;
    if ({A, B, C, D, Ap, Bp, Cp, Dp} !== '0) begin
      errors++;
      $display("FAIL midframe_reset: outputs=%h expected=0", {A, B, C, D, Ap, Bp, Cp, Dp});
    end
    repeat (2) @(negedge clk);
    cs = 0;
    repeat (3) @(negedge clk);
    reset = 1;
    repeat (50) begin
      @(negedge clk);
      if ({A, B, C, D, Ap, Bp, Cp, Dp} !== '0) bad++;
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL midframe_idle: nonzero cycles=%0d expected=0", bad);
    end
    send_packet(96'h000000_000000_ffff80_000000);
    repeat (5) @(negedge clk);
    check_counts("midframe", 0, 128, 0, 0);
  endtask

  initial begin
    test_reset();
    test_load();
    test_direction();
    test_amplitude();
    test_silence();
    test_reset_mid_frame();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/hdd_tone_top.md
Name: hdd_tone_top

Overview:
- Top level of the hard-drive music player.
- Receives one packet per update over a write-only SPI link. Each packet carries one 24-bit note word per track.
- Drives NUM_TRACKS stepper-style 4-phase coil outputs (A,B,C,D), one bit per track per phase, at the commanded step rate.
- Coil drive is amplitude-modulated by PWM or PDM, selected by parameter.

Parameters:
- NUM_TRACKS, 4: number of tracks and tone generators; packet length is 24*NUM_TRACKS bits.
- OUTPUT_TYPE, PWM: amplitude modulation scheme (output_types_t: PWM or PDM).
- TICK_DIV, 40: clk cycles per period tick. Must be ≥1.
- STEPS_PER_DIR, 16: steps taken before the step direction reverses.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- cs  in  1  SPI frame select, active high; falling edge commits the packet
- sck  in  1  SPI bit clock; sdi sampled on rising edge
- sdi  in  1  SPI serial data, MSB first
- A  out  NUM_TRACKS  coil phase A, bit k = track k
- B  out  NUM_TRACKS  coil phase B
- C  out  NUM_TRACKS  coil phase C
- D  out  NUM_TRACKS  coil phase D

Behaviour:
- Clocking:
  - One clock, clk. Reset is asynchronous and active-low (`reset` low = reset).
  - sck is an interface strobe, not a system clock. Only the SPI shift register uses its rising edge.
- SPI:
  - While cs=1, each sck rising edge shifts sdi into the LSB of a 24*NUM_TRACKS-bit register.
  - The first bit sent is packet MSB. Track k word = packet[24k+23:24k], so the last-sent 24 bits are track 0.
  - Frames longer than 24*NUM_TRACKS bits keep only the last 24*NUM_TRACKS bits. Shorter frames commit whatever the register holds.
- Commit:
  - cs is synchronized into clk with 2 flops. A falling edge detect copies the shift register into the track word registers.
  - New words take effect within 3 clk cycles of the cs fall.
  - A cs toggle with no sck pulses recommits the current register contents.
- Note word fields:
  - [23:8] period P: ticks between steps.
  - [7:0] amplitude M.
- Per-track step timer:
  - Counts ticks. Each tick is TICK_DIV clk cycles from a shared free-running prescaler.
  - Issues a step each time P ticks elapse.
  - P=0: track halted, no steps.
  - On commit, the step timer reloads to 0; phase and direction are retained.
- Phase sequence (two-phase-on):
  - States: AB(0) -> BC(1) -> CD(2) -> DA(3) -> AB, wrapping on forward steps; the reverse direction walks the sequence backwards.
  - Direction toggles after every STEPS_PER_DIR steps.
  - Reset state: phase AB, direction forward, step counter 0.
- Modulation:
  - Shared 8-bit free-running counter cnt, reset 0.
  - PWM: en = (cnt < M).
  - PDM: per-track 9-bit accumulator, acc <= acc[7:0] + M each clk; en = carry bit.
  - M=0: en always 0. M=255: PWM en low 1 cycle in 256; PDM en low 1 cycle in 256.
- Outputs:
  - Coil bit = phase-active AND en AND (P≠0).
  - Outputs are registered, one clk after internal state.
- Reset (mid-operation included):
  - All outputs 0; all track words 0 (silent); accumulators, counters and prescaler 0.
  - The SPI shift register is cleared asynchronously.
  - A cs fall that occurs during reset is ignored.

Decomposition:
- Shared package hdd_pkg: output_types_t enum {PWM, PDM}, PACKET_SIZE=24, field slice constants (PERIOD_MSB=23, PERIOD_LSB=8, AMP_MSB=7).
- Sub-module hdd_tone_gen: one per track, generated NUM_TRACKS times.
  - Inputs: tick, note word, modulation counter.
  - Outputs: 4 coil bits.
- SPI receive, prescaler and modulation counter live in the top.

Test Plan:
- Reset check: hold reset=0 → A,B,C,D all 0000. Release, no SPI traffic → outputs stay 0000 indefinitely.
- Load packet 0x0114ff_0217ff_0114ff_0217ff (96 bits, MSB first, cs high then low), TICK_DIV=1, PWM. Track0 P=0x0217=535, track1 P=0x0114=276.
  - Track1 steps every 276 clk.
  - Tracks 0/1 phase bits follow AB→BC→CD→DA.
  - Modulation duty is 255/256.
- Direction reverse: same setup, STEPS_PER_DIR=16 → after 16 steps track1 sequence reverses (DA→CD→BC…).
- Amplitude: M=0x80, PWM → coil high exactly 128 of every 256 clk while phase active. Same M with PDM → coil alternates 1,0 every cycle.
- Silence: send P=0x0000, M=0xff on all tracks → outputs 0 within 3 clk of cs fall.
- Reset mid-frame: assert reset after 40 of 96 bits, deassert, send a full packet → only the new packet is applied; the partial frame has no effect.
